// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Sums a stream of signed products into groups of LEN products. A group can
// also be closed early with in_last. Each completed group sum is held in
// registered result outputs until the consumer takes it. With SAT=1 the
// running sum clamps on signed overflow. With SAT=0 it wraps modulo 2^AW.
// In both modes the sticky overflow flag records any overflow in the group.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   in_data holds a product
//   in_ready   block can accept a product this cycle
//   in_data    signed product, PW bits
//   in_last    this product closes the group early
//   out_valid  result registers hold a completed group
//   out_ready  consumer accepts the result
//   out_data   signed group sum, AW bits
//   out_count  number of products in the group
//   out_ovf    at least one add in the group overflowed
// ---------------------------------------------------------------------------
module product_accumulator #(
  parameter int unsigned PW  = 8,
  parameter int unsigned AW  = 16,
  parameter int unsigned LEN = 4,
  parameter bit          SAT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic [3:0]    out_count,
  output logic          out_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] out_data_q, out_data_d;
  logic [3:0]    out_count_q, out_count_d;
  logic          out_ovf_q, out_ovf_d;

  logic          accept;
  logic          firstProduct;
  logic [AW-1:0] accBase;
  logic [3:0]    cntBase;
  logic          ovfBase;
  logic [AW:0]   addend;
  logic [AW:0]   sum;
  logic          sumOvf;
  logic [AW-1:0] sumClamped;
  logic [3:0]    cntNext;
  logic          closeGroup;

  assign in_ready  = (state_q != DONE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // The first product of a group adds onto a zero base, so it simply loads
  // the accumulator. It can never overflow, and it drops anything left over
  // from the previous group. One adder then serves both IDLE and ACC.
  always_comb begin
    accept       = in_valid && in_ready;
    firstProduct = (state_q == IDLE);
    accBase      = firstProduct ? '0   : acc_q;
    cntBase      = firstProduct ? 4'd0 : cnt_q;
    ovfBase      = firstProduct ? 1'b0 : ovf_q;
    addend       = {{(AW+1-PW){in_data[PW-1]}}, in_data};
    sum          = {accBase[AW-1], accBase} + addend;
    // The AW+1 bit sum overflowed AW when its top two bits disagree.
    sumOvf       = sum[AW] ^ sum[AW-1];
    if (sumOvf && SAT) begin
      sumClamped = sum[AW] ? ACC_MIN : ACC_MAX;
    end else begin
      sumClamped = sum[AW-1:0];
    end
    cntNext    = cntBase + 4'd1;
    closeGroup = in_last || (cntNext == 4'(LEN));
  end

  // Next-state logic. The result registers are loaded only on the edge that
  // enters DONE. They keep their value until the next group closes.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d = sumClamped;
          cnt_d = cntNext;
          ovf_d = ovfBase | sumOvf;
          if (closeGroup) begin
            state_d     = DONE;
            out_data_d  = sumClamped;
            out_count_d = cntNext;
            out_ovf_d   = ovfBase | sumOvf;
          end else begin
            state_d = ACC;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= 4'd0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= 4'd0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//
// Testbench for product_accumulator. Three instances share the same input
// stream and run in lockstep:
//   dut16 : default parameters (AW=16, SAT=1)
//   dutS9 : AW=9, SAT=1 (clamping)
//   dutW9 : AW=9, SAT=0 (wrapping)
// A table of groups is fed with hand-computed sums for each instance. It is
// followed by hand-written sequences for backpressure, bubbles and reset.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

  logic clk;
  logic rst;
  logic inValid;
  logic [7:0] inData;
  logic inLast;
  logic outReady;

  logic inReady16, inReadyS9, inReadyW9;
  logic outValid16, outValidS9, outValidW9;
  logic signed [15:0] outData16;
  logic signed [8:0]  outDataS9, outDataW9;
  logic [3:0] outCount16, outCountS9, outCountW9;
  logic outOvf16, outOvfS9, outOvfW9;

  int errors = 0;
  int checks = 0;

  product_accumulator dut16 (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady16), .in_data(inData), .in_last(inLast),
    .out_valid(outValid16), .out_ready(outReady), .out_data(outData16),
    .out_count(outCount16), .out_ovf(outOvf16)
  );

  product_accumulator #(.PW(8), .AW(9), .LEN(4), .SAT(1'b1)) dutS9 (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReadyS9), .in_data(inData), .in_last(inLast),
    .out_valid(outValidS9), .out_ready(outReady), .out_data(outDataS9),
    .out_count(outCountS9), .out_ovf(outOvfS9)
  );

  product_accumulator #(.PW(8), .AW(9), .LEN(4), .SAT(1'b0)) dutW9 (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReadyW9), .in_data(inData), .in_last(inLast),
    .out_valid(outValidW9), .out_ready(outReady), .out_data(outDataW9),
    .out_count(outCountW9), .out_ovf(outOvfW9)
  );

  // 10 time-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int p[4];
    int lastAt;
    int exp16;
    int ovf16;
    int expS9;
    int expW9;
    int ovf9;
  } vec_t;

  vec_t vecs[6];

  // Compare one value against its expected value and count the result.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one product and wait, with a bound, until it is accepted.
  // On return the accepting edge has passed by 1 time unit.
  task automatic applyStimulus(input int data, input logic last);
    int waitCnt;
    @(negedge clk);
    inValid = 1'b1;
    inData  = 8'(data);
    inLast  = last;
    waitCnt = 0;
    while (!inReady16 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!inReady16) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stuck at %0b, expected 1", inReady16);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inValid = 1'b0;
      inLast  = 1'b0;
    end
  endtask

  task automatic checkAllValid(input string name, input logic expected);
    checkOutput({name, "_valid16"}, int'(outValid16), int'(expected));
    checkOutput({name, "_validS9"}, int'(outValidS9), int'(expected));
    checkOutput({name, "_validW9"}, int'(outValidW9), int'(expected));
  endtask

  initial begin
    // Each record: count, products, index carrying in_last (-1 = none),
    // then the expected sums and overflow flags.
    vecs[0] = '{4, '{3, 5, 7, 9},           -1,   24, 0,   24,   24, 0};
    vecs[1] = '{4, '{-8, 127, -128, 1},     -1,   -8, 0,   -8,   -8, 0};
    vecs[2] = '{2, '{10, 20, 0, 0},          1,   30, 0,   30,   30, 0};
    vecs[3] = '{4, '{1, 1, 1, 1},           -1,    4, 0,    4,    4, 0};
    vecs[4] = '{4, '{127, 127, 127, 0},     -1,  381, 0,  255, -131, 1};
    vecs[5] = '{4, '{-128, -128, -128, 0},  -1, -384, 0, -256,  128, 1};

    rst      = 1'b1;
    inValid  = 1'b0;
    inData   = 8'd0;
    inLast   = 1'b0;
    outReady = 1'b1;

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    checkAllValid("reset", 1'b0);
    checkOutput("reset_in_ready", int'(inReady16), 0);
    checkOutput("reset_data16", int'(outData16), 0);
    checkOutput("reset_count16", int'(outCount16), 0);
    checkOutput("reset_ovf16", int'(outOvf16), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", int'(inReady16), 1);

    // Table-driven groups, back-to-back with out_ready held high.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        applyStimulus(vecs[v].p[k], (k == vecs[v].lastAt));
        if (k < vecs[v].n - 1) begin
          checkOutput($sformatf("v%0d_k%0d_no_early_valid", v, k), int'(outValid16), 0);
        end
      end
      // out_valid rises right after the closing accept.
      checkAllValid($sformatf("v%0d", v), 1'b1);
      checkOutput($sformatf("v%0d_in_ready", v), int'(inReady16), 0);
      checkOutput($sformatf("v%0d_data16", v), int'(outData16), vecs[v].exp16);
      checkOutput($sformatf("v%0d_dataS9", v), int'(outDataS9), vecs[v].expS9);
      checkOutput($sformatf("v%0d_dataW9", v), int'(outDataW9), vecs[v].expW9);
      checkOutput($sformatf("v%0d_count16", v), int'(outCount16), vecs[v].n);
      checkOutput($sformatf("v%0d_countS9", v), int'(outCountS9), vecs[v].n);
      checkOutput($sformatf("v%0d_ovf16", v), int'(outOvf16), vecs[v].ovf16);
      checkOutput($sformatf("v%0d_ovfS9", v), int'(outOvfS9), vecs[v].ovf9);
      checkOutput($sformatf("v%0d_ovfW9", v), int'(outOvfW9), vecs[v].ovf9);
      @(negedge clk);
      inValid = 1'b0;
      inLast  = 1'b0;
      // Released on the next edge: out_valid is high for exactly one cycle.
      @(posedge clk);
      #1;
      checkAllValid($sformatf("v%0d_released", v), 1'b0);
      checkOutput($sformatf("v%0d_in_ready_back", v), int'(inReady16), 1);
    end

    // Backpressure: the result holds while out_ready is low, and a product
    // offered during DONE is not absorbed.
    outReady = 1'b0;
    applyStimulus(1, 1'b0);
    applyStimulus(2, 1'b0);
    applyStimulus(3, 1'b0);
    applyStimulus(4, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      inValid = 1'b1;
      inData  = 8'd99;
      inLast  = 1'b1;
      checkOutput($sformatf("bp%0d_valid", c), int'(outValid16), 1);
      checkOutput($sformatf("bp%0d_in_ready", c), int'(inReady16), 0);
      checkOutput($sformatf("bp%0d_data", c), int'(outData16), 10);
      checkOutput($sformatf("bp%0d_count", c), int'(outCount16), 4);
    end
    @(negedge clk);
    inValid  = 1'b0;
    inLast   = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_released", int'(outValid16), 0);
    applyStimulus(1, 1'b0);
    applyStimulus(1, 1'b0);
    applyStimulus(1, 1'b0);
    applyStimulus(1, 1'b0);
    checkOutput("bp_next_valid", int'(outValid16), 1);
    checkOutput("bp_next_data", int'(outData16), 4);
    checkOutput("bp_next_count", int'(outCount16), 4);
    idleCycles(2);

    // Bubbles of three idle cycles between accepts.
    applyStimulus(5, 1'b0);
    idleCycles(3);
    applyStimulus(6, 1'b0);
    idleCycles(3);
    applyStimulus(7, 1'b0);
    idleCycles(3);
    checkOutput("bubble_no_early_valid", int'(outValid16), 0);
    applyStimulus(8, 1'b0);
    checkOutput("bubble_valid", int'(outValid16), 1);
    checkOutput("bubble_data16", int'(outData16), 26);
    checkOutput("bubble_dataS9", int'(outDataS9), 26);
    checkOutput("bubble_count", int'(outCount16), 4);
    idleCycles(2);

    // Reset in the middle of a group discards the partial sum.
    applyStimulus(50, 1'b0);
    applyStimulus(60, 1'b0);
    @(negedge clk);
    inValid = 1'b0;
    rst     = 1'b1;
    #1;
    checkOutput("rst_mid_in_ready", int'(inReady16), 0);
    @(posedge clk);
    #1;
    checkAllValid("rst_mid", 1'b0);
    checkOutput("rst_mid_data", int'(outData16), 0);
    checkOutput("rst_mid_count", int'(outCount16), 0);
    checkOutput("rst_mid_ovf", int'(outOvf16), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_in_ready_back", int'(inReady16), 1);
    idleCycles(2);
    checkOutput("rst_mid_no_result", int'(outValid16), 0);
    applyStimulus(1, 1'b0);
    applyStimulus(2, 1'b0);
    applyStimulus(3, 1'b0);
    checkOutput("rst_after_no_early_valid", int'(outValid16), 0);
    applyStimulus(4, 1'b0);
    checkOutput("rst_after_valid", int'(outValid16), 1);
    checkOutput("rst_after_data", int'(outData16), 10);
    checkOutput("rst_after_count", int'(outCount16), 4);
    idleCycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
